// File: rtl/prod_accum_pkg.sv
// Shared types and default widths for the product accumulator block.
package prod_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int PROD_W_D = 64;
    localparam int ACC_W_D  = 80;
    localparam int CNT_W_D  = 16;

endpackage

// File: rtl/prod_accum_if.sv
// Control, product and result handshake bundle for prod_accum_64.
interface prod_accum_if
    import prod_accum_pkg::*;
#(
    parameter int PROD_W = PROD_W_D,
    parameter int ACC_W  = ACC_W_D,
    parameter int CNT_W  = CNT_W_D
) ();
    logic              start;
    logic [CNT_W-1:0]  cfg_len;
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] product;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_sum;
    logic [CNT_W-1:0]  res_count;
    logic              res_ovf;
    logic              busy;

    modport master (
        output start, cfg_len, prod_valid, product, res_ready,
        input  prod_ready, res_valid, res_sum, res_count, res_ovf, busy
    );

    modport slave (
        input  start, cfg_len, prod_valid, product, res_ready,
        output prod_ready, res_valid, res_sum, res_count, res_ovf, busy
    );
endinterface

// File: rtl/prod_accum_add.sv
// Zero-extending accumulator adder with carry-out.
// PROD_ACCUM_SAT_EN selects saturation to all ones instead of modular wrap.
module prod_accum_add #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 80
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);
    logic [ACC_W-1:0] ext_s;
    logic [ACC_W:0]   raw_s;

    generate
        if (ACC_W > PROD_W) begin : g_ext
            assign ext_s = {{(ACC_W-PROD_W){1'b0}}, product};
        end else begin : g_same
            assign ext_s = product;
        end
    endgenerate

    // Full-width add; the extra MSB is the carry-out.
    always_comb begin
        raw_s = {1'b0, acc} + {1'b0, ext_s};
        carry = raw_s[ACC_W];
`ifdef PROD_ACCUM_SAT_EN
        if (raw_s[ACC_W]) begin
            sum = {ACC_W{1'b1}};
        end else begin
            sum = raw_s[ACC_W-1:0];
        end
`else
        sum = raw_s[ACC_W-1:0];
`endif
    end
endmodule

// File: rtl/prod_accum_64.sv
// Accumulates a programmed-length block of 64-bit products and returns sum/count/overflow.
// Build option: PROD_ACCUM_SAT_EN (saturating accumulator instead of wrap).
module prod_accum_64
    import prod_accum_pkg::*;
#(
    parameter int PROD_W = PROD_W_D,
    parameter int ACC_W  = ACC_W_D,
    parameter int CNT_W  = CNT_W_D
) (
    input logic         clk,
    input logic         rst_n,
    prod_accum_if.slave bus
);
    state_t            state_r;
    logic [ACC_W-1:0]  acc_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  len_r;
    logic              ovf_r;
    logic              prod_ready_r;
    logic              res_valid_r;
    logic [ACC_W-1:0]  res_sum_r;
    logic [CNT_W-1:0]  res_count_r;
    logic              res_ovf_r;
    logic              busy_r;

    logic [ACC_W-1:0]  sum_s;
    logic              carry_s;
    logic              hs_s;
    logic [CNT_W-1:0]  one_s;

    assign one_s = {{(CNT_W-1){1'b0}}, 1'b1};
    assign hs_s  = bus.prod_valid && prod_ready_r;

    prod_accum_add #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_add (
        .acc     (acc_r),
        .product (bus.product),
        .sum     (sum_s),
        .carry   (carry_s)
    );

    // Block FSM; result outputs are loaded on entry to HOLD and cleared on exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            acc_r        <= {ACC_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            len_r        <= {CNT_W{1'b0}};
            ovf_r        <= 1'b0;
            prod_ready_r <= 1'b0;
            res_valid_r  <= 1'b0;
            res_sum_r    <= {ACC_W{1'b0}};
            res_count_r  <= {CNT_W{1'b0}};
            res_ovf_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        len_r   <= bus.cfg_len;
                        acc_r   <= {ACC_W{1'b0}};
                        count_r <= {CNT_W{1'b0}};
                        ovf_r   <= 1'b0;
                        busy_r  <= 1'b1;
                        if (bus.cfg_len == {CNT_W{1'b0}}) begin
                            state_r     <= HOLD;
                            res_valid_r <= 1'b1;
                        end else begin
                            state_r      <= ACCUM;
                            prod_ready_r <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (hs_s) begin
                        acc_r   <= sum_s;
                        count_r <= count_r + one_s;
                        ovf_r   <= ovf_r | carry_s;
                        // Comparing against len-1 keeps count from ever wrapping at max length.
                        if (count_r == len_r - one_s) begin
                            state_r      <= HOLD;
                            prod_ready_r <= 1'b0;
                            res_valid_r  <= 1'b1;
                            res_sum_r    <= sum_s;
                            res_count_r  <= count_r + one_s;
                            res_ovf_r    <= ovf_r | carry_s;
                        end
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        state_r     <= IDLE;
                        res_valid_r <= 1'b0;
                        res_sum_r   <= {ACC_W{1'b0}};
                        res_count_r <= {CNT_W{1'b0}};
                        res_ovf_r   <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    prod_ready_r <= 1'b0;
                    res_valid_r  <= 1'b0;
                    res_sum_r    <= {ACC_W{1'b0}};
                    res_count_r  <= {CNT_W{1'b0}};
                    res_ovf_r    <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.prod_ready = prod_ready_r;
    assign bus.res_valid  = res_valid_r;
    assign bus.res_sum    = res_sum_r;
    assign bus.res_count  = res_count_r;
    assign bus.res_ovf    = res_ovf_r;
    assign bus.busy       = busy_r;
endmodule

// File: tb/tb_prod_accum_64.sv
// Directed scoreboard bench for prod_accum_64 (80-bit instance plus a 64-bit overflow instance).
module tb_prod_accum_64;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    typedef struct {
        logic [79:0] sum;
        logic [15:0] cnt;
        logic        ovf;
    } exp_t;
    exp_t sb[$];

    prod_accum_if #(.PROD_W(64), .ACC_W(80), .CNT_W(16)) a_if ();
    prod_accum_if #(.PROD_W(64), .ACC_W(64), .CNT_W(16)) b_if ();

    prod_accum_64 #(.PROD_W(64), .ACC_W(80), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(a_if.slave)
    );
    prod_accum_64 #(.PROD_W(64), .ACC_W(64), .CNT_W(16)) dut64 (
        .clk(clk), .rst_n(rst_n), .bus(b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [79:0] s, input logic [15:0] c, input logic o);
        exp_t e;
        e.sum = s; e.cnt = c; e.ovf = o;
        sb.push_back(e);
    endtask

    task automatic do_start(input logic [15:0] len);
        a_if.start   = 1'b1;
        a_if.cfg_len = len;
        tick();
        a_if.start   = 1'b0;
    endtask

    task automatic send(input logic [63:0] p);
        a_if.prod_valid = 1'b1;
        a_if.product    = p;
        for (int i = 0; i < 20 && !a_if.prod_ready; i++) tick();
        chk("prod_ready_wait", {79'd0, a_if.prod_ready}, 80'd1);
        tick();
        a_if.prod_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int stall);
        exp_t e;
        for (int i = 0; i < 20 && !a_if.res_valid; i++) tick();
        chk({tag, "_res_valid"}, {79'd0, a_if.res_valid}, 80'd1);
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s_sb_empty observed=0 expected=1", tag);
        end else begin
            e = sb.pop_front();
            for (int i = 0; i < stall; i++) begin
                chk({tag, "_stall_sum"}, a_if.res_sum, e.sum);
                chk({tag, "_stall_prdy"}, {79'd0, a_if.prod_ready}, 80'd0);
                tick();
            end
            chk({tag, "_sum"}, a_if.res_sum, e.sum);
            chk({tag, "_count"}, {64'd0, a_if.res_count}, {64'd0, e.cnt});
            chk({tag, "_ovf"}, {79'd0, a_if.res_ovf}, {79'd0, e.ovf});
            a_if.res_ready = 1'b1;
            tick();
            a_if.res_ready = 1'b0;
            chk({tag, "_after_valid"}, {79'd0, a_if.res_valid}, 80'd0);
            chk({tag, "_after_sum"}, a_if.res_sum, 80'd0);
        end
    endtask

    initial begin
        logic [63:0] pa;
        logic [63:0] pb;
        logic [63:0] exp64;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        a_if.start = 1'b0; a_if.cfg_len = 16'd0; a_if.prod_valid = 1'b0;
        a_if.product = 64'd0; a_if.res_ready = 1'b0;
        b_if.start = 1'b0; b_if.cfg_len = 16'd0; b_if.prod_valid = 1'b0;
        b_if.product = 64'd0; b_if.res_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", {79'd0, a_if.busy}, 80'd0);
        chk("rst_prdy", {79'd0, a_if.prod_ready}, 80'd0);
        chk("rst_rvalid", {79'd0, a_if.res_valid}, 80'd0);
        chk("rst_sum", a_if.res_sum, 80'd0);
        rst_n = 1'b1;
        tick();

        // Basic block with latency check
        push(80'h0000_FFFF_FFFF_0000_0011, 16'd3, 1'b0);
        do_start(16'd3);
        chk("basic_prdy", {79'd0, a_if.prod_ready}, 80'd1);
        chk("basic_busy", {79'd0, a_if.busy}, 80'd1);
        chk("basic_sum_accum", a_if.res_sum, 80'd0);
        a_if.prod_valid = 1'b1;
        a_if.product = 64'd6;                   tick();
        chk("basic_no_early_valid", {79'd0, a_if.res_valid}, 80'd0);
        a_if.product = 64'd10;                  tick();
        a_if.product = 64'hFFFF_FFFF_0000_0001; tick();
        a_if.prod_valid = 1'b0;
        chk("basic_latency", {79'd0, a_if.res_valid}, 80'd1);
        collect("basic", 0);
        tick();

        // Bubbles and result backpressure
        pa = 64'h1234_5678_9ABC_DEF0;
        pb = 64'h0FED_CBA9_8765_4321;
        push({16'd0, pa} + {16'd0, pb}, 16'd2, 1'b0);
        do_start(16'd2);
        send(pa);
        for (int i = 0; i < 3; i++) tick();
        chk("bubble_busy", {79'd0, a_if.busy}, 80'd1);
        chk("bubble_no_valid", {79'd0, a_if.res_valid}, 80'd0);
        send(pb);
        collect("bp", 5);
        tick();

        // Zero length goes straight to HOLD and accepts nothing
        push(80'd0, 16'd0, 1'b0);
        a_if.prod_valid = 1'b1;
        a_if.product = 64'd99;
        do_start(16'd0);
        chk("zero_valid", {79'd0, a_if.res_valid}, 80'd1);
        chk("zero_prdy", {79'd0, a_if.prod_ready}, 80'd0);
        collect("zero", 2);
        a_if.prod_valid = 1'b0;
        tick();

        // Asynchronous reset mid-block
        do_start(16'd4);
        send(64'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {79'd0, a_if.busy}, 80'd0);
        chk("arst_prdy", {79'd0, a_if.prod_ready}, 80'd0);
        chk("arst_valid", {79'd0, a_if.res_valid}, 80'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_busy", {79'd0, a_if.busy}, 80'd0);
        chk("post_rst_valid", {79'd0, a_if.res_valid}, 80'd0);
        push(80'd5, 16'd1, 1'b0);
        do_start(16'd1);
        send(64'd5);
        collect("after_rst", 0);
        tick();

        // Start ignored in ACCUM and in HOLD (even with res_ready)
        push(80'd7, 16'd2, 1'b0);
        do_start(16'd2);
        send(64'd3);
        a_if.start = 1'b1; a_if.cfg_len = 16'd9;
        tick();
        a_if.start = 1'b0;
        send(64'd4);
        chk("ign_hold", {79'd0, a_if.res_valid}, 80'd1);
        begin
            exp_t e;
            e = sb.pop_front();
            chk("ign_sum", a_if.res_sum, e.sum);
            chk("ign_count", {64'd0, a_if.res_count}, {64'd0, e.cnt});
        end
        a_if.start = 1'b1; a_if.cfg_len = 16'd1; a_if.res_ready = 1'b1;
        tick();
        a_if.start = 1'b0; a_if.res_ready = 1'b0;
        chk("ign_idle_busy", {79'd0, a_if.busy}, 80'd0);
        tick();
        chk("ign_still_idle", {79'd0, a_if.busy}, 80'd0);
        push(80'd11, 16'd1, 1'b0);
        do_start(16'd1);
        send(64'd11);
        collect("ign_next", 0);

        // Overflow on the 64-bit accumulator instance
`ifdef PROD_ACCUM_SAT_EN
        exp64 = 64'hFFFF_FFFF_FFFF_FFFF;
`else
        exp64 = 64'd1;
`endif
        b_if.start = 1'b1; b_if.cfg_len = 16'd2;
        tick();
        b_if.start = 1'b0;
        b_if.prod_valid = 1'b1;
        b_if.product = 64'hFFFF_FFFF_FFFF_FFFF; tick();
        b_if.product = 64'd2;                   tick();
        b_if.prod_valid = 1'b0;
        chk("ovf_valid", {79'd0, b_if.res_valid}, 80'd1);
        chk("ovf_sum", {16'd0, b_if.res_sum}, {16'd0, exp64});
        chk("ovf_flag", {79'd0, b_if.res_ovf}, 80'd1);
        chk("ovf_count", {64'd0, b_if.res_count}, 80'd2);
        b_if.res_ready = 1'b1;
        tick();
        b_if.res_ready = 1'b0;
        chk("ovf_cleared", {79'd0, b_if.res_ovf}, 80'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/prod_accum_64.md
Name: prod_accum_64

Overview:
- Downstream consumer of the 32x32 unsigned combinational multiplier's 64-bit product.
- Accumulates a programmed number of products (one dot-product block) into a wide accumulator.
- Exchanges data upstream and downstream through valid/ready handshakes.
- Reports the final sum, the product count and a sticky overflow flag for each block.

Parameters:
- PROD_W, 64, product input width (unsigned).
- ACC_W, 80, accumulator/result width; must be >= PROD_W.
- CNT_W, 16, width of the block-length and count fields.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a block; sampled only in IDLE.
- cfg_len  in  CNT_W  number of products in the block; sampled together with start.
- prod_valid  in  1  product input valid.
- prod_ready  out  1  block accepts a product this cycle.
- product  in  PROD_W  unsigned product from the multiplier.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_sum  out  ACC_W  accumulated sum.
- res_count  out  CNT_W  number of products accumulated.
- res_ovf  out  1  sticky: accumulator wrapped (or saturated) during the block.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - acc, count, len_q, ovf all zero.
  - Every output is 0: prod_ready, res_valid, res_sum, res_count, res_ovf, busy.
  - Assertion mid-block discards the partial sum with no result emitted; same for mid-hold.
- Three states: IDLE, ACCUM, HOLD.
- IDLE: prod_ready=0, res_valid=0. When start=1:
  - latch len_q=cfg_len; clear acc, count and ovf.
  - next state ACCUM; if cfg_len=0, next state HOLD directly (sum 0, count 0).
- ACCUM:
  - prod_ready=1.
  - A handshake is prod_valid && prod_ready. On a handshake: acc <= acc + zero_extend(product); count <= count+1.
  - ovf is set if the ACC_W-bit add carries out.
  - If count == len_q-1 at the handshake, next state is HOLD.
  - Cycles with no handshake hold all state.
  - start is ignored.
- HOLD:
  - res_valid=1; res_sum, res_count and res_ovf are driven from registers.
  - All result outputs are stable until res_ready=1. On res_ready=1 the next state is IDLE.
  - prod_ready=0. start is ignored, including in the same cycle as res_ready.
- Latency:
  - res_valid rises the cycle after the final product handshake.
  - Minimum start-to-result time is len+1 cycles.
  - A back-to-back block needs one IDLE cycle: the earliest new start is the cycle after the result handshake.
- Outputs are registered or state-decoded only; there is no combinational path from prod_valid or res_ready to any output.
- res_sum, res_count and res_ovf read zero in IDLE and ACCUM, and are valid only in HOLD.
- Wrap-around: without the optional feature, acc wraps modulo 2^ACC_W and ovf stays set until the next start.
- Max count: cfg_len = 2^CNT_W-1 is legal and count never wraps.

Optional Feature:
- Macro: PROD_ACCUM_SAT_EN.
- Defined: on carry-out, acc saturates to all ones (2^ACC_W-1) and stays saturated for the rest of the block. ovf is still set and count still increments.
- Undefined: modular wrap as described above. The rest of the interface and timing are identical.

Decomposition:
- Package prod_accum_pkg holds:
  - the state enum (IDLE, ACCUM, HOLD);
  - default width constants PROD_W_D=64, ACC_W_D=80, CNT_W_D=16.
- One sub-module: prod_accum_add.
  - Combinational ACC_W adder: zero-extends product and returns sum and carry.
  - Contains the saturation mux under PROD_ACCUM_SAT_EN.
- The FSM and registers live in the top module.

Test Plan:
- Basic block: reset; start with cfg_len=3; products 6, 10, 0xFFFFFFFF00000001 (valid every cycle).
  - Expect res_valid 4 cycles after start, res_sum=0xFFFFFFFF00000011, res_count=3, res_ovf=0.
- Backpressure and bubbles: cfg_len=2, prod_valid gapped by 3 idle cycles, res_ready held low for 5 cycles.
  - Expect res_sum=sum of the two products, held stable across the stall.
  - Expect prod_ready=0 throughout HOLD.
- Zero length: start with cfg_len=0.
  - Expect HOLD on the next cycle: res_sum=0, res_count=0, res_ovf=0, and no product accepted.
- Overflow: ACC_W=64; cfg_len=2; products 0xFFFFFFFFFFFFFFFF and 2.
  - Without macro: res_sum=1, res_ovf=1.
  - With PROD_ACCUM_SAT_EN: res_sum=0xFFFFFFFFFFFFFFFF, res_ovf=1.
- Reset mid-block: assert rst_n=0 after 1 of 4 products.
  - Expect all outputs 0 immediately (asynchronous), busy=0 and no res_valid afterwards.
  - A new start with cfg_len=1 and product 5 must then yield res_sum=5.
- Ignored start: pulse start during ACCUM and during HOLD with res_ready=1.
  - Expect no restart and no change to len_q or acc; the next block starts only from IDLE.
